// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants, types and helpers for the regbank_sb
// register bank with write-pending scoreboard.
package regbank_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);

  // Upper bound for the popcount helper; DEPTH must not exceed this.
  localparam int MAX_DEPTH = 1024;

  typedef logic [DEF_AW-1:0]    reg_addr_t;
  typedef logic [DEF_WIDTH-1:0] reg_data_t;

  // Hardwired-zero register index: never stored, never busy.
  localparam reg_addr_t ZERO_REG = reg_addr_t'(0);

  // Number of set bits in a busy vector (zero-extended to MAX_DEPTH).
  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regbank_rport.sv
// regbank_rport: one combinational read port of regbank_sb.
// Selects the addressed register and busy bit, forces register 0 to read
// as zero and not busy. With REGBANK_BYPASS_EN defined, a same-cycle write
// to the addressed register is forwarded (data = wd, busy = 0) unless the
// bank is in reset.
module regbank_rport
  import regbank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   rst,
  input  logic [DEPTH*WIDTH-1:0] mem_flat,
  input  logic [DEPTH-1:0]       busy_vec,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [AW-1:0]          ra,
  output logic [WIDTH-1:0]       rd,
  output logic                   rbusy
);

`ifndef REGBANK_BYPASS_EN
  // Write-port signals only matter when forwarding is built in.
  logic unused_wr_s;
  assign unused_wr_s = ^{rst, we, wa, wd};
`endif

  // Address mux with zero-register override and optional write forwarding.
  always_comb begin
    rd    = '0;
    rbusy = 1'b0;
    if (ra == AW'(ZERO_REG)) begin
      rd    = '0;
      rbusy = 1'b0;
    end
`ifdef REGBANK_BYPASS_EN
    else if (!rst && we && (wa != AW'(ZERO_REG)) && (ra == wa)) begin
      rd    = wd;
      rbusy = 1'b0;
    end
`endif
    else begin
      rd    = mem_flat[int'(ra)*WIDTH +: WIDTH];
      rbusy = busy_vec[ra];
    end
  end

endmodule

// File: rtl/regbank_sb.sv
// regbank_sb: register bank with integrated write-pending scoreboard.
// NREAD combinational read ports, one synchronous write port, hardwired
// zero register, per-register busy bits (set by issue, cleared by
// writeback; set wins on a same-register collision) and a registered
// busy count. Optional macro REGBANK_BYPASS_EN enables same-cycle
// write-to-read forwarding in every read port.
module regbank_sb
  import regbank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREAD-1:0][AW-1:0]    ra,
  output logic [NREAD-1:0][WIDTH-1:0] rd,
  output logic [NREAD-1:0]            rbusy,
  input  logic                        we,
  input  logic [AW-1:0]               wa,
  input  logic [WIDTH-1:0]            wd,
  input  logic                        set_busy,
  input  logic [AW-1:0]               sa,
  output logic [AW:0]                 busy_cnt
);

  // Storage for registers 1..DEPTH-1; register 0 has none.
  logic [WIDTH-1:0]       mem_r [1:DEPTH-1];
  logic [DEPTH*WIDTH-1:0] mem_flat_s;
  logic [DEPTH-1:0]       busy_r;
  logic [DEPTH-1:0]       busy_next_s;
  logic [MAX_DEPTH-1:0]   busy_ext_s;

  // Flattened view of the register file with slot 0 tied to zero.
  assign mem_flat_s[0 +: WIDTH] = '0;
  for (genvar g = 1; g < DEPTH; g++) begin : g_flat
    assign mem_flat_s[g*WIDTH +: WIDTH] = mem_r[g];
  end

  // Register file update: reset clears all, otherwise the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (we && (wa == AW'(i))) begin
          mem_r[i] <= wd;
        end
      end
    end
  end

  // Next busy vector: reset clears, a new producer beats a writeback clear.
  always_comb begin
    busy_next_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 32'sd0) begin
        busy_next_s[i] = 1'b0;
      end else if (rst) begin
        busy_next_s[i] = 1'b0;
      end else if (set_busy && (sa == AW'(i))) begin
        busy_next_s[i] = 1'b1;
      end else if (we && (wa == AW'(i))) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_r[i];
      end
    end
  end

  // Zero-extend the next busy vector for the popcount helper.
  always_comb begin
    busy_ext_s              = '0;
    busy_ext_s[DEPTH-1:0]   = busy_next_s;
  end

  // Busy bits and their count, registered together so they always agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_r   <= busy_next_s;
      busy_cnt <= (AW+1)'(popcount(busy_ext_s));
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rport
    regbank_rport #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_rport (
      .rst      (rst),
      .mem_flat (mem_flat_s),
      .busy_vec (busy_r),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .ra       (ra[p]),
      .rd       (rd[p]),
      .rbusy    (rbusy[p])
    );
  end

endmodule

// File: tb/tb_regbank_sb.sv
// tb_regbank_sb: directed self-checking bench for regbank_sb (NREAD=3).
// Expected values are hand-computed; bypass expectations follow
// REGBANK_BYPASS_EN.
module tb_regbank_sb;
  import regbank_pkg::*;

  localparam int NR = 3;

  logic                 clk;
  logic                 rst;
  logic [NR-1:0][4:0]   ra;
  logic [NR-1:0][31:0]  rd;
  logic [NR-1:0]        rbusy;
  logic                 we;
  logic [4:0]           wa;
  logic [31:0]          wd;
  logic                 set_busy;
  logic [4:0]           sa;
  logic [5:0]           busy_cnt;

  int checks;
  int errors;

  regbank_sb #(.WIDTH(32), .DEPTH(32), .NREAD(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .ra       (ra),
    .rd       (rd),
    .rbusy    (rbusy),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .set_busy (set_busy),
    .sa       (sa),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = 5'd0; wd = 32'd0; set_busy = 1'b0; sa = 5'd0;
  endtask

  task automatic ra_all(input logic [4:0] a);
    for (int p = 0; p < NR; p++) ra[p] = a;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    idle();
  endtask

  task automatic setb(input logic [4:0] a);
    set_busy = 1'b1; sa = a;
    tick();
    idle();
  endtask

  initial begin
    logic bypass;
    checks = 0;
    errors = 0;
`ifdef REGBANK_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    rst = 1'b1;
    idle();
    ra_all(5'd0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state on every address and port.
    chk("rst_cnt", 32'(busy_cnt), 32'd0);
    for (int a = 0; a < 32; a++) begin
      ra_all(5'(a));
      #1;
      for (int p = 0; p < NR; p++) begin
        chk($sformatf("rst_rd a%0d p%0d", a, p), rd[p], 32'd0);
        chk($sformatf("rst_rb a%0d p%0d", a, p), 32'(rbusy[p]), 32'd0);
      end
    end

    // Zero register ignores writes and scoreboard sets.
    wr(5'd0, 32'hDEADBEEF);
    ra_all(5'd0);
    #1;
    chk("zero_rd", rd[0], 32'd0);
    setb(5'd0);
    chk("zero_cnt", 32'(busy_cnt), 32'd0);
    chk("zero_rb", 32'(rbusy[1]), 32'd0);

    // Plain writes to non-busy registers, read on distinct ports.
    wr(5'd4, 32'h11111111);
    wr(5'd9, 32'hCAFEF00D);
    wr(5'd2, 32'h00000022);
    wr(5'd31, 32'h80000001);
    ra[0] = 5'd4; ra[1] = 5'd9; ra[2] = 5'd31;
    #1;
    chk("wr_r4", rd[0], 32'h11111111);
    chk("wr_r9", rd[1], 32'hCAFEF00D);
    chk("wr_r31", rd[2], 32'h80000001);
    chk("wr_rb4", 32'(rbusy[0]), 32'd0);
    chk("wr_cnt", 32'(busy_cnt), 32'd0);

    // Scoreboard round trip on r5.
    setb(5'd5);
    ra_all(5'd5);
    #1;
    chk("sb_rb", 32'(rbusy[0]), 32'd1);
    chk("sb_cnt", 32'(busy_cnt), 32'd1);
    we = 1'b1; wa = 5'd5; wd = 32'h00001234;
    #1;
    chk("sb_same_rd", rd[1], bypass ? 32'h00001234 : 32'd0);
    chk("sb_same_rb", 32'(rbusy[1]), bypass ? 32'd0 : 32'd1);
    tick();
    idle();
    chk("sb_rd", rd[0], 32'h00001234);
    chk("sb_rb_clr", 32'(rbusy[2]), 32'd0);
    chk("sb_cnt_clr", 32'(busy_cnt), 32'd0);

    // Same-cycle set and clear of r7: set wins, data still written.
    setb(5'd7);
    chk("sc_pre_cnt", 32'(busy_cnt), 32'd1);
    set_busy = 1'b1; sa = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'd9;
    tick();
    idle();
    ra_all(5'd7);
    #1;
    chk("sc_rd", rd[0], 32'd9);
    chk("sc_rb", 32'(rbusy[0]), 32'd1);
    chk("sc_cnt", 32'(busy_cnt), 32'd1);

    // Set one register while clearing another: count unchanged.
    set_busy = 1'b1; sa = 5'd1; we = 1'b1; wa = 5'd7; wd = 32'd10;
    tick();
    idle();
    chk("xc_cnt", 32'(busy_cnt), 32'd1);
    ra[0] = 5'd1; ra[1] = 5'd7;
    #1;
    chk("xc_rb1", 32'(rbusy[0]), 32'd1);
    chk("xc_rb7", 32'(rbusy[1]), 32'd0);

    // Bypass: all ports on r3, write A5A5A5A5 over 3333.
    wr(5'd3, 32'h00003333);
    ra_all(5'd3);
    we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5;
    #1;
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("byp_same p%0d", p), rd[p], bypass ? 32'hA5A5A5A5 : 32'h00003333);
    end
    tick();
    idle();
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("byp_next p%0d", p), rd[p], 32'hA5A5A5A5);
    end

    // Reset mid-operation: r1..r10 busy, then rst with a write to r2.
    for (int a = 1; a <= 10; a++) setb(5'(a));
    chk("mr_cnt10", 32'(busy_cnt), 32'd10);
    ra_all(5'd2);
    rst = 1'b1; we = 1'b1; wa = 5'd2; wd = 32'hFFFFFFFF;
    #1;
    chk("mr_rst_rd", rd[0], 32'h00000022);
    chk("mr_rst_rb", 32'(rbusy[0]), 32'd1);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("mr_cnt", 32'(busy_cnt), 32'd0);
    chk("mr_rd2", rd[1], 32'd0);
    chk("mr_rb2", 32'(rbusy[2]), 32'd0);
    ra_all(5'd9);
    #1;
    chk("mr_rd9", rd[0], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
